// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   Architectural integer register file (x0 hard-wired to zero) with two
//   combinational read ports and a per-register busy scoreboard used by
//   decode to stall on read-after-write hazards.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   : a writeback is visible on the read ports in the same cycle,
//                 and the matching rsN_busy is cleared in that cycle.
//     undefined : read ports only see stored state; the writeback becomes
//                 visible (data and busy) one cycle later.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset (clears regs and busy bits)
//   i_wb_en      writeback strobe
//   i_wb_addr    writeback destination index
//   i_wb_data    writeback word
//   i_rs1_addr   read port 1 index     -> o_rs1_data / o_rs1_busy
//   i_rs2_addr   read port 2 index     -> o_rs2_data / o_rs2_busy
//   i_issue_en   an instruction with a destination issues this cycle
//   i_issue_rd   destination index of the issuing instruction
//   o_busy_vec   raw scoreboard bits (bit 0 always 0)
// ---------------------------------------------------------------------------

// One read port: data + busy lookup, with optional same-cycle write-through.
module register_file_rdport #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic [AW-1:0]                    i_addr,
  input  logic [NUM_REGS-1:0][XLEN-1:0]    i_regs,
  input  logic [NUM_REGS-1:0]              i_busy,
  input  logic                             i_wb_en,
  input  logic [AW-1:0]                    i_wb_addr,
  input  logic [XLEN-1:0]                  i_wb_data,
  input  logic                             i_issue_en,
  input  logic [AW-1:0]                    i_issue_rd,
  output logic [XLEN-1:0]                  o_data,
  output logic                             o_busy
);

`ifdef REGFILE_BYPASS_EN
  logic w_wb_hit;
  assign w_wb_hit = i_wb_en && (i_wb_addr != '0) && (i_wb_addr == i_addr);
`else
  // Bypass inputs are only consumed when write-through is built in.
  logic w_unused_nobyp;
  assign w_unused_nobyp = ^{i_wb_en, i_wb_addr, i_wb_data, i_issue_en, i_issue_rd};
`endif

  // Entry 0 of i_regs / i_busy is tied to zero, so x0 needs no special case.
  always_comb begin
    o_data = i_regs[i_addr];
    o_busy = i_busy[i_addr];
`ifdef REGFILE_BYPASS_EN
    if (w_wb_hit) begin
      o_data = i_wb_data;
      // A producer issuing to the same rd this cycle takes ownership again.
      o_busy = i_issue_en && (i_issue_rd == i_addr);
    end
`endif
  end

endmodule

module register_file #(
  parameter  int NUM_REGS = 32,
  parameter  int XLEN     = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wb_en,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [XLEN-1:0]      i_wb_data,
  input  logic [AW-1:0]        i_rs1_addr,
  input  logic [AW-1:0]        i_rs2_addr,
  output logic [XLEN-1:0]      o_rs1_data,
  output logic [XLEN-1:0]      o_rs2_data,
  input  logic                 i_issue_en,
  input  logic [AW-1:0]        i_issue_rd,
  output logic                 o_rs1_busy,
  output logic                 o_rs2_busy,
  output logic [NUM_REGS-1:0]  o_busy_vec
);

  localparam int NUM_RD = 2;

  // x1..x(NUM_REGS-1); x0 has no storage.
  logic [NUM_REGS-1:1][XLEN-1:0] r_regs;
  logic [NUM_REGS-1:0]           r_busy;

  // Full-width view with a constant-zero x0 slot for the read muxes.
  logic [NUM_REGS-1:0][XLEN-1:0] w_regs;
  assign w_regs = {r_regs, {XLEN{1'b0}}};

  logic w_wb_wr;
  assign w_wb_wr = i_wb_en && (i_wb_addr != '0);

  // ---- register array ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regs <= '0;
    end else if (w_wb_wr) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  // ---- scoreboard ----
  // Set has priority over clear: a same-cycle issue to the register being
  // written back is a younger producer that still owns it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy[0] <= 1'b0;
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_issue_en && (i_issue_rd == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (i_wb_en && (i_wb_addr == AW'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign o_busy_vec = r_busy;

  // ---- read ports ----
  logic [NUM_RD-1:0][AW-1:0]   w_rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0] w_rd_data;
  logic [NUM_RD-1:0]           w_rd_busy;

  assign w_rd_addr = {i_rs2_addr, i_rs1_addr};

  genvar g;
  generate
    for (g = 0; g < NUM_RD; g++) begin : g_rd
      register_file_rdport #(
        .NUM_REGS (NUM_REGS),
        .XLEN     (XLEN),
        .AW       (AW)
      ) u_rdport (
        .i_addr     (w_rd_addr[g]),
        .i_regs     (w_regs),
        .i_busy     (r_busy),
        .i_wb_en    (i_wb_en),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .i_issue_en (i_issue_en),
        .i_issue_rd (i_issue_rd),
        .o_data     (w_rd_data[g]),
        .o_busy     (w_rd_busy[g])
      );
    end
  endgenerate

  assign o_rs1_data = w_rd_data[0];
  assign o_rs2_data = w_rd_data[1];
  assign o_rs1_busy = w_rd_busy[0];
  assign o_rs2_busy = w_rd_busy[1];

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst, wb_en, issue_en;
  logic [4:0]  wb_addr, rs1_addr, rs2_addr, issue_rd;
  logic [31:0] wb_data;
  logic [31:0] rs1_data, rs2_data, busy_vec;
  logic        rs1_busy, rs2_busy;

  always #5 clk = ~clk;

  register_file #(.NUM_REGS(32), .XLEN(32)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_wb_en    (wb_en),
    .i_wb_addr  (wb_addr),
    .i_wb_data  (wb_data),
    .i_rs1_addr (rs1_addr),
    .i_rs2_addr (rs2_addr),
    .o_rs1_data (rs1_data),
    .o_rs2_data (rs2_data),
    .i_issue_en (issue_en),
    .i_issue_rd (issue_rd),
    .o_rs1_busy (rs1_busy),
    .o_rs2_busy (rs2_busy),
    .o_busy_vec (busy_vec)
  );

  int nchk  = 0;
  int nfail = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // Reference model: architectural state as plain arrays.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (BYP && wb_en && wb_addr == a) return issue_en && (issue_rd == a);
    return m_busy[a];
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [31:0] v;
    v = '0;
    for (int i = 1; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rs1_data"}, rs1_data, exp_data(rs1_addr));
    chk({tag, ".rs2_data"}, rs2_data, exp_data(rs2_addr));
    chk({tag, ".rs1_busy"}, {31'b0, rs1_busy}, {31'b0, exp_busy(rs1_addr)});
    chk({tag, ".rs2_busy"}, {31'b0, rs2_busy}, {31'b0, exp_busy(rs2_addr)});
    chk({tag, ".busy_vec"}, busy_vec, exp_vec());
  endtask

  // Advance one clock edge; the model absorbs whatever inputs were applied.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wb_en && wb_addr != 0) begin
        m_regs[wb_addr] = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wb_en = 0; issue_en = 0; wb_addr = 0; issue_rd = 0; wb_data = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
    rst = 1; idle(); rs1_addr = 0; rs2_addr = 0;
    @(negedge clk);
    tick(); tick();
    rst = 0;
    #1;
    chk("rst.busy_vec", busy_vec, 32'h0);
    chk("rst.rs1_busy", {31'b0, rs1_busy}, 32'h0);

    // Every register reads zero after reset.
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
      #1;
      chk("rst.rd1", rs1_data, 32'h0);
      chk("rst.rd2", rs2_data, 32'h0);
      tick();
    end

    // Writes and issues to x0 are dropped.
    wb_en = 1; wb_addr = 0; wb_data = 32'hDEADBEEF;
    tick(); idle();
    rs1_addr = 0; #1;
    chk("x0.read", rs1_data, 32'h0);
    issue_en = 1; issue_rd = 0;
    tick(); idle(); #1;
    chk("x0.busy_vec", busy_vec, 32'h0);

    // Write x5 with both ports reading it in the same cycle.
    wb_en = 1; wb_addr = 5; wb_data = 32'h12345678;
    rs1_addr = 5; rs2_addr = 5; #1;
    chk("x5.wb_rd1", rs1_data, BYP ? 32'h12345678 : 32'h0);
    chk("x5.wb_rd2", rs2_data, BYP ? 32'h12345678 : 32'h0);
    check_all("x5.wb");
    tick(); idle(); #1;
    chk("x5.next_rd1", rs1_data, 32'h12345678);
    chk("x5.next_rd2", rs2_data, 32'h12345678);

    // Busy on x7 held until writeback.
    issue_en = 1; issue_rd = 7;
    tick(); idle();
    rs1_addr = 7; rs2_addr = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("x7.busy_hold", {31'b0, rs1_busy}, 32'h1);
      tick();
    end
    wb_en = 1; wb_addr = 7; wb_data = 32'hA5A5A5A5; #1;
    chk("x7.wb_busy", {31'b0, rs1_busy}, BYP ? 32'h0 : 32'h1);
    chk("x7.wb_data", rs1_data, BYP ? 32'hA5A5A5A5 : 32'h0);
    tick(); idle(); #1;
    chk("x7.after_busy", {31'b0, rs1_busy}, 32'h0);
    chk("x7.after_data", rs1_data, 32'hA5A5A5A5);

    // Same-cycle issue and writeback to x9: set wins.
    rs1_addr = 9;
    issue_en = 1; issue_rd = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h0BADF00D;
    tick(); idle(); #1;
    chk("x9.busy_vec", {31'b0, busy_vec[9]}, 32'h1);
    chk("x9.rs1_busy", {31'b0, rs1_busy}, 32'h1);
    chk("x9.data", rs1_data, 32'h0BADF00D);
    // Again with x9 already busy: stays busy during and after the cycle.
    issue_en = 1; issue_rd = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h13579BDF; #1;
    chk("x9.again_busy", {31'b0, rs1_busy}, 32'h1);
    check_all("x9.again");
    tick(); idle(); #1;
    chk("x9.again_after", {31'b0, rs1_busy}, 32'h1);
    chk("x9.again_data", rs1_data, 32'h13579BDF);

    // Mid-operation reset discards everything; writes during reset are dropped.
    issue_en = 1; issue_rd = 3;
    tick(); idle();
    issue_en = 1; issue_rd = 4; wb_en = 1; wb_addr = 3; wb_data = 32'h1;
    tick(); idle(); #1;
    chk("rst2.pre_vec", busy_vec & 32'h0000_0218, 32'h0000_0210);
    rst = 1; wb_en = 1; wb_addr = 10; wb_data = 32'h55AA55AA;
    tick(); rst = 0; idle();
    rs1_addr = 3; rs2_addr = 10; #1;
    chk("rst2.busy_vec", busy_vec, 32'h0);
    chk("rst2.x3", rs1_data, 32'h0);
    chk("rst2.x10", rs2_data, 32'h0);
    check_all("rst2");

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rst      = ($urandom_range(0, 99) < 2);
      wb_en    = ($urandom_range(0, 99) < 50);
      wb_addr  = 5'($urandom_range(0, 31));
      wb_data  = $urandom;
      issue_en = ($urandom_range(0, 99) < 35);
      issue_rd = 5'($urandom_range(0, 31));
      rs1_addr = ($urandom_range(0, 3) == 0) ? wb_addr : 5'($urandom_range(0, 31));
      rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : 5'($urandom_range(0, 31));
      // Keep same-cycle issue+writeback to one rd only where the register is
      // already owned, the only case the pipeline produces.
      if (issue_en && wb_en && issue_rd == wb_addr && !m_busy[wb_addr]) issue_en = 0;
      #1;
      if (!rst) check_all("rand");
      tick();
    end
    idle(); rst = 0; #1;
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural 32 x 32-bit integer register file for the RV32 core, sitting at the consuming end of the writeback path. It accepts the selected writeback word (ALU, load, PC+4 or immediate) together with a destination index, and serves two combinational read ports to decode. An integrated busy-bit scoreboard tracks registers with an in-flight producer so that decode can stall on read-after-write hazards until the matching writeback lands.

## Interface
- NUM_REGS, 32, number of architectural registers; index width = $clog2(NUM_REGS).
- XLEN, 32, data width.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- wb_en  in  1  writeback strobe.
- wb_addr  in  5  writeback destination index.
- wb_data  in  XLEN  writeback word.
- rs1_addr  in  5  read port 1 index.
- rs2_addr  in  5  read port 2 index.
- rs1_data  out  XLEN  read port 1 data (combinational).
- rs2_data  out  XLEN  read port 2 data (combinational).
- issue_en  in  1  an instruction with a register destination issues this cycle.
- issue_rd  in  5  destination index of the issuing instruction.
- rs1_busy  out  1  rs1_addr has an outstanding producer.
- rs2_busy  out  1  rs2_addr has an outstanding producer.
- busy_vec  out  NUM_REGS  raw scoreboard bits (debug/verification).

## Operation
- Storage: regs[1..31], XLEN bits each. x0 is not stored; a read of index 0 returns 0. A write to index 0 is dropped.
- Write: on a rising edge with wb_en=1, rst=0 and wb_addr!=0, regs[wb_addr] <= wb_data.
- Read: rsN_data = 0 if rsN_addr==0; otherwise it returns regs[rsN_addr], subject to the bypass described under Configuration.
- Scoreboard, per register i with i!=0:
  - Set: issue_en=1 and issue_rd==i.
  - Clear: wb_en=1 and wb_addr==i.
  - Set and clear in the same cycle for the same i: set wins, and busy stays 1 because the younger producer now owns the register.
  - Set on an already-busy register leaves it at 1. No counting; the pipeline issues at most one producer per rd in flight.
  - busy[0] is always 0, and issue_rd==0 is ignored.
- rsN_busy = busy[rsN_addr], subject to the bypass described under Configuration.
- The block has no FSM. State is the register array plus busy_vec.

## Timing
- Reset, held one or more cycles: all regs <= 0 and busy_vec <= 0. Writes and issues presented while rst=1 are ignored.
  - On the first cycle after rst deasserts, rs1_data = rs2_data = 0, rs1_busy = rs2_busy = 0, and busy_vec = 0.
- Reset asserted mid-operation discards all pending busy bits and register contents on that edge. The pipeline must be flushed by the same reset.
- Write latency: one edge. Data written at edge N is visible from regs after edge N.
- Read latency: zero, purely combinational from addresses and state. No output register.
- Scoreboard latency: a set or clear takes effect at the edge. busy_vec reflects it in the following cycle.
- Both read ports may address the same register, and may address wb_addr, in the same cycle. Both return the identical value.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When wb_en=1, wb_addr!=0 and rsN_addr==wb_addr, rsN_data = wb_data in the same cycle (write-through).
  - rsN_busy is forced to 0 in that case unless issue_en=1 with issue_rd==rsN_addr in the same cycle.
  - Net effect: a consumer can issue in the writeback cycle.
- Undefined:
  - Reads return only the stored regs value, so the old value is visible during the writeback cycle.
  - rsN_busy = busy[rsN_addr] with no same-cycle override. The consumer therefore stalls one extra cycle.

## Test plan
- Reset, then read x0..x31 on both ports -> every read returns 0x00000000, and busy_vec = 0.
- wb_en=1, wb_addr=0, wb_data=0xDEADBEEF; next cycle rs1_addr=0 -> rs1_data = 0. Separately, issue_en=1 with issue_rd=0 -> busy_vec stays 0.
- Write x5=0x12345678 at edge N; with rs1_addr=rs2_addr=5 in the same cycle as the write:
  - Bypass on: both ports return 0x12345678.
  - Bypass off: both ports return 0.
  - In both builds, both ports return 0x12345678 on the next cycle.
- issue_en with issue_rd=7, then rs1_addr=7 -> rs1_busy=1 for 3 cycles. wb_en with wb_addr=7, wb_data=0xA5A5A5A5:
  - Bypass on: rs1_busy=0 and rs1_data=0xA5A5A5A5 in that same cycle.
  - Bypass off: both take effect one cycle later.
- Same cycle: issue_en with issue_rd=9, and wb_en with wb_addr=9 -> busy[9]=1 after the edge, regs[9]=wb_data, and rs1_busy stays 1 for rs1_addr=9.
- Set busy[3], busy[4] and write x3=1, then assert rst for one cycle -> busy_vec=0, x3 reads 0, and a wb_en=1 presented during rst is not written.
